// File: rtl/wb_timing_pkg.sv
// Shared types and Wishbone width constants for the timing-measuring Wishbone master.
package wb_timing_pkg;

   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned SEL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_timing_master.sv
// Wishbone classic master: one command at a time, measures ack latency,
// abandons a stalled cycle after TIMEOUT_CYC stb cycles and keeps simple statistics.
//
// state | meaning
// IDLE  | cmd_ready_o high, waiting for a command
// BUS   | cyc/stb asserted, counting latency, watching ack/err/timeout
// RESP  | rsp_valid_o high, response held until rsp_ready_i
module wb_timing_master
   import wb_timing_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned LAT_W       = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_we_i,
   input  logic [SEL_W-1:0] cmd_sel_i,
   input  logic [ADR_W-1:0] cmd_adr_i,
   input  logic [DAT_W-1:0] cmd_dat_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [DAT_W-1:0] rsp_dat_o,
   output logic             rsp_err_o,
   output logic             rsp_timeout_o,
   output logic [LAT_W-1:0] rsp_lat_o,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [SEL_W-1:0] wbm_sel_o,
   output logic [ADR_W-1:0] wbm_adr_o,
   output logic [DAT_W-1:0] wbm_dat_o,
   input  logic             wbm_ack_i,
   input  logic             wbm_err_i,
   input  logic [DAT_W-1:0] wbm_dat_i,
   output logic [31:0]      stat_txn_o,
   output logic [LAT_W-1:0] stat_max_lat_o
);

   localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYC - 1);

   wb_state_e        state_q, state_d;
   logic             cyc_q, we_q;
   logic [SEL_W-1:0] sel_q;
   logic [ADR_W-1:0] adr_q;
   logic [DAT_W-1:0] dat_q;
   logic [LAT_W-1:0] lat_q;
   logic [15:0]      to_q;
   logic [DAT_W-1:0] rsp_dat_q;
   logic             rsp_err_q, rsp_to_q;
   logic [LAT_W-1:0] rsp_lat_q;
   logic [31:0]      txn_q;
   logic [LAT_W-1:0] max_lat_q;

   logic cmd_fire, bus_hit, to_hit, rsp_fire;

   assign cmd_fire = (state_q == ST_IDLE) && cmd_valid_i;
   assign bus_hit  = (state_q == ST_BUS) && (wbm_ack_i || wbm_err_i);
   assign to_hit   = (state_q == ST_BUS) && !bus_hit && (to_q == 16'd0);
   assign rsp_fire = (state_q == ST_RESP) && rsp_ready_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_valid_i)                 state_d = ST_BUS;
         ST_BUS:  if (bus_hit || to_hit)           state_d = ST_RESP;
         ST_RESP: if (rsp_ready_i)                 state_d = ST_IDLE;
         default:                                  state_d = ST_IDLE;
      endcase
   end

   // Ready is gated by the reset pin so it reads low for the whole reset pulse.
   always_comb begin
      cmd_ready_o = (state_q == ST_IDLE) && wb_rst_ni;
      rsp_valid_o = (state_q == ST_RESP);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         lat_q     <= '0;
         to_q      <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
         rsp_to_q  <= 1'b0;
         rsp_lat_q <= '0;
         txn_q     <= '0;
         max_lat_q <= '0;
      end else begin
         if (cmd_fire) begin
            cyc_q <= 1'b1;
            we_q  <= cmd_we_i;
            sel_q <= cmd_sel_i;
            adr_q <= cmd_adr_i;
            dat_q <= cmd_dat_i;
            lat_q <= LAT_W'(1);
            to_q  <= TO_LOAD;
         end else if (bus_hit) begin
            cyc_q     <= 1'b0;
            rsp_dat_q <= we_q ? '0 : wbm_dat_i;
            rsp_err_q <= wbm_err_i;
            rsp_to_q  <= 1'b0;
            rsp_lat_q <= lat_q;
            if (lat_q > max_lat_q) max_lat_q <= lat_q;
         end else if (to_hit) begin
            cyc_q     <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_to_q  <= 1'b1;
            rsp_lat_q <= lat_q;
         end else if (state_q == ST_BUS) begin
            if (lat_q != '1) lat_q <= lat_q + 1'b1;
            to_q <= to_q - 16'd1;
         end
         if (rsp_fire) txn_q <= txn_q + 32'd1;
      end
   end

   assign wbm_cyc_o      = cyc_q;
   assign wbm_stb_o      = cyc_q;
   assign wbm_we_o       = we_q;
   assign wbm_sel_o      = sel_q;
   assign wbm_adr_o      = adr_q;
   assign wbm_dat_o      = dat_q;
   assign rsp_dat_o      = rsp_dat_q;
   assign rsp_err_o      = rsp_err_q;
   assign rsp_timeout_o  = rsp_to_q;
   assign rsp_lat_o      = rsp_lat_q;
   assign stat_txn_o     = txn_q;
   assign stat_max_lat_o = max_lat_q;

endmodule

// File: tb/tb_wb_timing_master.sv
// Directed bench for wb_timing_master: writes, reads, timeout, ack+err,
// response back-pressure and mid-transaction reset.
module tb_wb_timing_master;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [3:0]  cmd_sel_i = '0;
   logic [31:0] cmd_adr_i = '0;
   logic [31:0] cmd_dat_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic [15:0] rsp_lat_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_err_i = 1'b0;
   logic [31:0] wbm_dat_i = '0;
   logic [31:0] stat_txn_o;
   logic [15:0] stat_max_lat_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_timing_master #(.TIMEOUT_CYC(8), .LAT_W(16)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_we_i(cmd_we_i), .cmd_sel_i(cmd_sel_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
      .rsp_lat_o(rsp_lat_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i),
      .stat_txn_o(stat_txn_o), .stat_max_lat_o(stat_max_lat_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Issue one command; ack_cyc = 0 means the slave stays silent.
   task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input int ack_cyc, input logic ack,
                          input logic err, input logic [31:0] rdat);
      @(negedge wb_clk_i);
      cmd_we_i = we; cmd_sel_i = sel; cmd_adr_i = adr; cmd_dat_i = dat; cmd_valid_i = 1'b1;
      @(posedge wb_clk_i); #1;
      cmd_valid_i = 1'b0;
      chk("launch_cyc", {wbm_cyc_o, wbm_stb_o}, 2'b11);
      chk("launch_ready", cmd_ready_o, 1'b0);
      if (ack_cyc > 0) begin
         repeat (ack_cyc - 1) begin @(posedge wb_clk_i); #1; end
         wbm_ack_i = ack; wbm_err_i = err; wbm_dat_i = rdat;
         @(posedge wb_clk_i); #1;
         wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
         chk("rsp_valid", rsp_valid_o, 1'b1);
         chk("cyc_drop", wbm_cyc_o, 1'b0);
      end
   endtask

   task automatic rsp_handshake();
      @(negedge wb_clk_i);
      rsp_ready_i = 1'b1;
      @(posedge wb_clk_i); #1;
      rsp_ready_i = 1'b0;
      chk("post_hs_ready", cmd_ready_o, 1'b1);
      chk("post_hs_valid", rsp_valid_o, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      // reset state
      #22;
      chk("rst_cyc", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b000);
      chk("rst_ready", cmd_ready_o, 1'b0);
      chk("rst_valid", rsp_valid_o, 1'b0);
      chk("rst_stats", {stat_txn_o, stat_max_lat_o}, '0);
      @(negedge wb_clk_i); wb_rst_ni = 1'b1; #1;
      chk("rel_ready", cmd_ready_o, 1'b1);

      // write, ack on first stb cycle
      run_txn(1'b1, 4'hF, 32'h3000_0000, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, 32'h5555_5555);
      chk("w_dat_o", wbm_dat_o, 32'hDEAD_BEEF);
      chk("w_adr_o", wbm_adr_o, 32'h3000_0000);
      chk("w_we_o", wbm_we_o, 1'b1);
      chk("w_lat", rsp_lat_o, 16'd1);
      chk("w_err", {rsp_err_o, rsp_timeout_o}, 2'b00);
      chk("w_rdat_zero", rsp_dat_o, 32'h0);
      rsp_handshake();
      chk("w_txn", stat_txn_o, 32'd1);
      chk("w_max", stat_max_lat_o, 16'd1);

      // read, ack after 4 stb cycles
      run_txn(1'b0, 4'h3, 32'h0000_0100, 32'hCAFE_0000, 4, 1'b1, 1'b0, 32'h1234_5678);
      chk("r_dat", rsp_dat_o, 32'h1234_5678);
      chk("r_lat", rsp_lat_o, 16'd4);
      chk("r_max", stat_max_lat_o, 16'd4);
      chk("r_we_o", wbm_we_o, 1'b0);
      chk("r_sel_dat_o", {wbm_sel_o, wbm_dat_o}, {4'h3, 32'hCAFE_0000});
      rsp_handshake();
      chk("r_txn", stat_txn_o, 32'd2);

      // timeout: slave silent, count stb cycles
      run_txn(1'b0, 4'hF, 32'h0000_0200, 32'h0, 0, 1'b0, 1'b0, 32'h0);
      cnt = 0;
      while (wbm_cyc_o && cnt < 20) begin cnt++; @(posedge wb_clk_i); #1; end
      chk("to_stb_cycles", cnt, 8);
      chk("to_flag", {rsp_valid_o, rsp_timeout_o, rsp_err_o}, 3'b110);
      chk("to_lat", rsp_lat_o, 16'd8);
      chk("to_dat", rsp_dat_o, 32'h0);
      repeat (2) @(posedge wb_clk_i);
      #1 wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
      @(posedge wb_clk_i); #1;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
      chk("late_ack_fields", {rsp_timeout_o, rsp_err_o, rsp_dat_o, rsp_lat_o},
          {1'b1, 1'b0, 32'h0, 16'd8});
      chk("to_max_kept", stat_max_lat_o, 16'd4);
      rsp_handshake();
      chk("to_txn", stat_txn_o, 32'd3);

      // ack and err together on the second cycle
      run_txn(1'b0, 4'hF, 32'h0000_0300, 32'h0, 2, 1'b1, 1'b1, 32'hA5A5_A5A5);
      chk("ae_err", {rsp_err_o, rsp_timeout_o}, 2'b10);
      chk("ae_lat", rsp_lat_o, 16'd2);
      chk("ae_dat", rsp_dat_o, 32'hA5A5_A5A5);
      rsp_handshake();
      chk("ae_txn", stat_txn_o, 32'd4);

      // back-pressure: response held, next command waits for the handshake
      run_txn(1'b1, 4'h1, 32'h0000_0400, 32'h0000_0011, 3, 1'b1, 1'b0, 32'h0);
      @(negedge wb_clk_i);
      cmd_we_i = 1'b0; cmd_sel_i = 4'h2; cmd_adr_i = 32'h0000_0500; cmd_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge wb_clk_i);
         chk("bp_hold", {rsp_valid_o, cmd_ready_o, wbm_cyc_o, rsp_lat_o, rsp_err_o},
             {3'b100, 16'd3, 1'b0});
      end
      rsp_ready_i = 1'b1;
      @(posedge wb_clk_i); #1;
      rsp_ready_i = 1'b0;
      chk("bp_idle", {cmd_ready_o, wbm_cyc_o, rsp_valid_o}, 3'b100);
      chk("bp_txn", stat_txn_o, 32'd5);
      @(posedge wb_clk_i); #1;
      cmd_valid_i = 1'b0;
      chk("bp_accept", {wbm_cyc_o, wbm_adr_o}, {1'b1, 32'h0000_0500});
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
      @(posedge wb_clk_i); #1;
      wbm_ack_i = 1'b0; wbm_dat_i = '0;
      chk("bp2_rsp", {rsp_valid_o, rsp_lat_o, rsp_dat_o}, {1'b1, 16'd1, 32'h0BAD_F00D});
      rsp_handshake();
      chk("bp2_txn_max", {stat_txn_o, stat_max_lat_o}, {32'd6, 16'd4});

      // reset during BUS at latency 3
      run_txn(1'b0, 4'hF, 32'h0000_0600, 32'h0, 0, 1'b0, 1'b0, 32'h0);
      repeat (2) begin @(posedge wb_clk_i); #1; end
      chk("pre_rst_cyc", wbm_cyc_o, 1'b1);
      #2 wb_rst_ni = 1'b0;
      #1;
      chk("arst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o}, '0);
      chk("arst_rsp", {rsp_valid_o, rsp_lat_o, rsp_dat_o, rsp_timeout_o}, '0);
      chk("arst_stats", {stat_txn_o, stat_max_lat_o, cmd_ready_o}, '0);
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i); wb_rst_ni = 1'b1; #1;
      chk("rel2_ready", {cmd_ready_o, rsp_valid_o}, 2'b10);
      run_txn(1'b1, 4'hC, 32'h0000_0700, 32'h7777_0000, 2, 1'b1, 1'b0, 32'h0);
      chk("post_rst_lat", rsp_lat_o, 16'd2);
      rsp_handshake();
      chk("post_rst_stats", {stat_txn_o, stat_max_lat_o}, {32'd1, 16'd2});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
